// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state type and helpers for the vending controller
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } vend_state_t;

    localparam int MAX_PROD    = 32;
    localparam int PRICE_VEC_W = 256;

    typedef logic [MAX_PROD-1:0]    prod_vec_t;
    typedef logic [PRICE_VEC_W-1:0] price_vec_t;

    // Two's-complement trick isolates the lowest set bit as a one-hot word.
    function automatic prod_vec_t lowest_set(input prod_vec_t v);
        return v & (~v + prod_vec_t'(1));
    endfunction

    function automatic logic [31:0] price_of(input price_vec_t prices, input int idx, input int w);
        price_vec_t  shifted;
        logic [31:0] mask;
        shifted = prices >> (idx * w);
        mask    = (32'd1 << w) - 32'd1;
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/vend_down_counter.sv
// rtl/vend_down_counter.sv - loadable down counter that stops at zero
module vend_down_counter #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vending_ctrl_param.sv
// rtl/vending_ctrl_param.sv - multi-product vending controller with refund and idle timeout
module vending_ctrl_param
    import vending_pkg::*;
#(
    parameter int                          CREDIT_W     = 5,
    parameter int                          MAX_CREDIT   = 16,
    parameter int                          N_PROD       = 3,
    parameter logic [N_PROD*CREDIT_W-1:0]  PRICES       = {5'd4, 5'd3, 5'd2},
    parameter int                          DISPENSE_CYC = 2,
    parameter int                          IDLE_TIMEOUT = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Coin,
    input  logic                Req_Change,
    input  logic [N_PROD-1:0]   Select,
    output logic [CREDIT_W-1:0] Credit,
    output logic [N_PROD-1:0]   Dispense,
    output logic                Change_Out,
    output logic                Busy,
    output logic                Coin_Reject,
    output logic                Deny
);

    localparam int DW = $clog2(DISPENSE_CYC + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    vend_state_t         state, state_n;
    logic [CREDIT_W-1:0] credit_n, sel_price;
    logic [CREDIT_W-1:0] price_tbl [N_PROD];
    logic [N_PROD-1:0]   sel_oh, dispense_n;
    logic                change_out_n, busy_n, coin_reject_n, deny_n;
    logic [IW-1:0]       idle_cnt, idle_n;
    logic                idle_expired;
    logic                dsp_load, dsp_dec, dsp_zero;
    logic                chg_load, chg_dec, chg_zero;

    for (genvar g = 0; g < N_PROD; g++) begin : g_price
        assign price_tbl[g] = CREDIT_W'(price_of(price_vec_t'(PRICES), g, CREDIT_W));
    end

    assign sel_oh = N_PROD'(lowest_set(prod_vec_t'(Select)));

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_oh[i]) sel_price = price_tbl[i];
        end
    end

    // This cycle's quiet increment is the one that reaches IDLE_TIMEOUT.
    assign idle_expired = (Credit != '0) && (idle_cnt == IW'(IDLE_TIMEOUT - 1));

    always_comb begin
        state_n       = state;
        credit_n      = Credit;
        dispense_n    = Dispense;
        change_out_n  = Change_Out;
        coin_reject_n = 1'b0;
        deny_n        = 1'b0;
        idle_n        = '0;
        dsp_load      = 1'b0;
        dsp_dec       = 1'b0;
        chg_load      = 1'b0;
        chg_dec       = 1'b0;
        case (state)
            IDLE: begin
                if (Coin) begin
                    if (Credit < CREDIT_W'(MAX_CREDIT)) credit_n = Credit + CREDIT_W'(1);
                    else                                coin_reject_n = 1'b1;
                end else if (|Select) begin
                    if (Credit >= sel_price) begin
                        credit_n   = Credit - sel_price;
                        dispense_n = sel_oh;
                        dsp_load   = 1'b1;
                        state_n    = DISPENSE;
                    end else begin
                        deny_n = 1'b1;
                    end
                end else if (Req_Change || idle_expired) begin
                    if (Credit != '0) begin
                        chg_load     = 1'b1;
                        credit_n     = '0;
                        change_out_n = 1'b1;
                        state_n      = CHANGE;
                    end
                end else if (Credit != '0) begin
                    idle_n = idle_cnt + IW'(1);
                end
            end
            DISPENSE: begin
                coin_reject_n = Coin;
                if (dsp_zero) begin
                    dispense_n = '0;
                    state_n    = IDLE;
                end else begin
                    dsp_dec = 1'b1;
                end
            end
            CHANGE: begin
                coin_reject_n = Coin;
                if (chg_zero) begin
                    change_out_n = 1'b0;
                    state_n      = IDLE;
                end else begin
                    chg_dec = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            Credit      <= '0;
            Dispense    <= '0;
            Change_Out  <= 1'b0;
            Busy        <= 1'b0;
            Coin_Reject <= 1'b0;
            Deny        <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_n;
            Credit      <= credit_n;
            Dispense    <= dispense_n;
            Change_Out  <= change_out_n;
            Busy        <= busy_n;
            Coin_Reject <= coin_reject_n;
            Deny        <= deny_n;
            idle_cnt    <= idle_n;
        end
    end

    // Counters hold the units remaining after the one already driven out.
    vend_down_counter #(.W(DW)) u_dsp_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (dsp_load),
        .load_val (DW'(DISPENSE_CYC - 1)),
        .dec      (dsp_dec),
        .zero     (dsp_zero)
    );

    vend_down_counter #(.W(CREDIT_W)) u_chg_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (chg_load),
        .load_val (Credit - CREDIT_W'(1)),
        .dec      (chg_dec),
        .zero     (chg_zero)
    );

endmodule

// File: tb/tb_vending_ctrl_param.sv
// tb/tb_vending_ctrl_param.sv - randomized bench against a cycle-schedule reference model
module tb_vending_ctrl_param;

    localparam int CW   = 5;
    localparam int MAXC = 16;
    localparam int NP   = 3;
    localparam int DC   = 2;
    localparam int IT   = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Coin = 1'b0;
    logic          Req_Change = 1'b0;
    logic [NP-1:0] Select = '0;
    logic [CW-1:0] Credit;
    logic [NP-1:0] Dispense;
    logic          Change_Out;
    logic          Busy;
    logic          Coin_Reject;
    logic          Deny;

    int errors = 0;
    int checks = 0;

    int price_tab [NP] = '{2, 3, 4};

    // Model: busy outputs are visible on every cycle up to m_busy_end.
    int          t          = 0;
    int          m_credit   = 0;
    int          m_busy_end = -1;
    int          m_quiet    = 0;
    bit          m_is_chg   = 1'b0;
    logic [NP-1:0] m_disp   = '0;

    vending_ctrl_param #(
        .CREDIT_W     (CW),
        .MAX_CREDIT   (MAXC),
        .N_PROD       (NP),
        .PRICES       ({5'd4, 5'd3, 5'd2}),
        .DISPENSE_CYC (DC),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Coin        (Coin),
        .Req_Change  (Req_Change),
        .Select      (Select),
        .Credit      (Credit),
        .Dispense    (Dispense),
        .Change_Out  (Change_Out),
        .Busy        (Busy),
        .Coin_Reject (Coin_Reject),
        .Deny        (Deny)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    task automatic cycle(input bit c, input logic [NP-1:0] s, input bit r, input bit rst);
        bit e_rej, e_deny, e_busy, trig;
        int idx;
        Coin = c; Select = s; Req_Change = r; Reset = rst;
        e_rej = 0; e_deny = 0;
        if (rst) begin
            m_credit = 0; m_busy_end = t; m_quiet = 0;
        end else if (t <= m_busy_end) begin
            e_rej = c;
        end else if (c) begin
            m_quiet = 0;
            if (m_credit < MAXC) m_credit++;
            else                 e_rej = 1;
        end else if (s != 0) begin
            m_quiet = 0;
            idx = 0;
            while (!s[idx]) idx++;
            if (m_credit >= price_tab[idx]) begin
                m_credit  -= price_tab[idx];
                m_is_chg   = 0;
                m_disp     = NP'(1) << idx;
                m_busy_end = t + DC;
            end else begin
                e_deny = 1;
            end
        end else begin
            trig = r;
            if (r) m_quiet = 0;
            else if (m_credit != 0) begin
                m_quiet++;
                if (m_quiet == IT) trig = 1;
            end
            if (trig && m_credit != 0) begin
                m_is_chg   = 1;
                m_busy_end = t + m_credit;
                m_credit   = 0;
                m_quiet    = 0;
            end
        end
        e_busy = (t + 1 <= m_busy_end);
        @(posedge Clock);
        #1;
        t++;
        chk("credit",      Credit,      m_credit);
        chk("busy",        Busy,        e_busy);
        chk("dispense",    Dispense,    (e_busy && !m_is_chg) ? m_disp : '0);
        chk("change_out",  Change_Out,  e_busy && m_is_chg);
        chk("coin_reject", Coin_Reject, e_rej);
        chk("deny",        Deny,        e_deny);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) cycle(1, '0, 0, 0);
    endtask

    initial begin
        int pulses;
        int roll;

        cycle(0, '0, 0, 1);
        cycle(0, '0, 0, 1);

        coins(3);
        cycle(0, 3'b001, 0, 0);
        chk("plan_sel_credit", Credit, 1);
        chk("plan_sel_disp",   Dispense, 1);
        quiet(8);

        cycle(0, '0, 0, 1);
        coins(2);
        cycle(0, 3'b100, 0, 0);
        chk("plan_deny",        Deny, 1);
        chk("plan_deny_credit", Credit, 2);
        cycle(0, 3'b110, 0, 0);
        quiet(6);

        cycle(0, '0, 0, 1);
        coins(17);
        chk("plan_sat",     Credit, MAXC);
        chk("plan_sat_rej", Coin_Reject, 1);
        quiet(20);

        cycle(0, '0, 0, 1);
        coins(5);
        cycle(0, '0, 1, 0);
        chk("plan_refund_credit", Credit, 0);
        pulses = Change_Out;
        cycle(1, 3'b001, 1, 0);
        chk("plan_refund_rej", Coin_Reject, 1);
        pulses += Change_Out;
        for (int i = 0; i < 6; i++) begin
            cycle(0, '0, 0, 0);
            pulses += Change_Out;
        end
        chk("plan_refund_pulses", pulses, 5);

        cycle(0, '0, 0, 1);
        coins(1);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(0, '0, 0, 0);
            pulses += Change_Out;
        end
        chk("plan_timeout_pulses", pulses, 1);

        coins(3);
        cycle(0, 3'b010, 0, 0);
        cycle(0, '0, 0, 1);
        chk("plan_rst_disp", Dispense, 0);
        quiet(2);
        coins(4);
        cycle(0, '0, 1, 0);
        quiet(1);
        cycle(0, '0, 0, 1);
        chk("plan_rst_chg", Change_Out, 0);
        quiet(4);

        for (int i = 0; i < 3000; i++) begin
            roll = $urandom_range(0, 99);
            if (roll < 2)       cycle(0, '0, 0, 1);
            else if (roll < 40) cycle(1, NP'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 0);
            else if (roll < 60) cycle(0, NP'($urandom_range(1, 7)), $urandom_range(0, 1) == 1, 0);
            else if (roll < 66) cycle(0, '0, 1, 0);
            else                cycle(0, '0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
